// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
// Shares one "four equal bits in a row" detector among four serial
// requester channels. Each channel keeps its own {last_bit, run} context.
// The shared datapath serves one granted channel per cycle. The result is
// returned one edge later as a one-hot ack together with the detect flag.
//
// Build option:
//   SEQ_SCHED_RR_EN  defined   -> round-robin arbitration. The search starts
//                                 at the pointer + 1, and the pointer follows
//                                 each grant.
//                    undefined -> fixed priority. The lowest eligible index
//                                 wins, and no pointer exists.
module seq_detect_scheduler #(
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   w,
    input  logic [NCH-1:0]   ctx_clr,
    output logic [NCH-1:0]   ack,
    output logic             det_valid,
    output logic [1:0]       det_ch,
    output logic             det,
    output logic             busy
);

    localparam logic [2:0] RUN_MAX = 3'd4;

    logic [NCH-1:0]        last_q, last_d;
    logic [NCH-1:0][2:0]   run_q, run_d;
    logic [NCH-1:0]        ack_q, ack_d;
    logic                  det_valid_q, det_valid_d;
    logic [1:0]            det_ch_q, det_ch_d;
    logic                  det_q, det_d;

    logic [NCH-1:0]        elig;
    logic                  gnt_vld;
    logic [1:0]            gnt_idx;

    // A channel acked at the last edge is masked so its held request is not consumed twice.
    assign elig = req & ~ack_q;
    assign busy = |elig;

`ifdef SEQ_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;

    // Round-robin search that begins just after the most recently granted channel.
    always_comb begin
        logic [1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= NCH; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        ptr_d = gnt_vld ? gnt_idx : ptr_q;
    end

    // The pointer resets to 3 so that channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 2'd3;
        else       ptr_q <= ptr_d;
    end
`else
    // Fixed priority: the lowest eligible index wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_vld && elig[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = 2'(k);
            end
        end
    end
`endif

    // Context update for the granted channel, context clears, and the next result outputs.
    always_comb begin
        logic [2:0] cur_run;
        logic       cur_last;
        logic [2:0] new_run;

        last_d      = last_q;
        run_d       = run_q;
        ack_d       = '0;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        det_d       = det_q;
        cur_run     = 3'd0;
        cur_last    = 1'b0;
        new_run     = 3'd0;

        for (int i = 0; i < NCH; i++) begin
            if (ctx_clr[i]) begin
                last_d[i] = 1'b0;
                run_d[i]  = 3'd0;
            end
        end

        if (gnt_vld) begin
            // When a clear coincides with a grant, the clear takes effect first; the bit is then consumed from a fresh context.
            cur_run  = ctx_clr[gnt_idx] ? 3'd0 : run_q[gnt_idx];
            cur_last = ctx_clr[gnt_idx] ? 1'b0 : last_q[gnt_idx];
            if (cur_run == 3'd0 || w[gnt_idx] != cur_last)
                new_run = 3'd1;
            else if (cur_run >= RUN_MAX)
                new_run = RUN_MAX;
            else
                new_run = cur_run + 3'd1;

            run_d[gnt_idx]  = new_run;
            last_d[gnt_idx] = w[gnt_idx];
            ack_d           = NCH'(1) << gnt_idx;
            det_valid_d     = 1'b1;
            det_ch_d        = gnt_idx;
            det_d           = (new_run == RUN_MAX);
        end
    end

    // State and output registers; reset overrides any grant or clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= '0;
            run_q       <= '0;
            ack_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= 2'd0;
            det_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            run_q       <= run_d;
            ack_q       <= ack_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_q       <= det_d;
        end
    end

    assign ack       = ack_q;
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign det       = det_q;

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of serial requester channels; the legal value is 4 only.
REQ-002 The block SHALL have port clk, input, width 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, width 4: per-channel request; the channel holds a bit for the shared detector.
REQ-005 The block SHALL have port w, input, width 4: per-channel serial data bit, valid while req[i]=1.
REQ-006 The block SHALL have port ctx_clr, input, width 4: per-channel context clear.
REQ-007 The block SHALL have port ack, output, width 4: one-hot registered pulse; ack[i]=1 means the bit on channel i was consumed at the previous edge.
REQ-008 The block SHALL have port det_valid, output, width 1: result strobe, registered, coincident with ack.
REQ-009 The block SHALL have port det_ch, output, width 2: index of the channel the result belongs to.
REQ-010 The block SHALL have port det, output, width 1: the detect flag for det_ch.
REQ-011 The block SHALL have port busy, output, width 1: high when any unmasked req[i] is high in the current cycle (combinational).

Function
REQ-012 The block SHALL time-share one detector datapath among 4 channels, keeping a per-channel context {last_bit, run[2:0]} with run saturating at 4.
REQ-013 A channel i SHALL be eligible in a cycle iff req[i]=1 and ack[i]=0; ack[i]=1 masks i for that cycle to prevent double consumption.
REQ-014 Each cycle, the arbiter SHALL grant at most one eligible channel g; with no eligible channel there is no grant and no state change except ctx_clr.
REQ-015 At the edge ending a grant cycle for g, the context of g SHALL update: if run=0 or w[g]!=last_bit, then run=1; else run=min(run+1,4); last_bit=w[g].
REQ-016 At the same edge, the outputs SHALL become ack=1<<g, det_valid=1, det_ch=g, and det=1 iff the new run equals 4 (overlapping runs of four equal bits, so det stays 1 for the 5th and later equal bits).
REQ-017 Latency from req to ack/det SHALL be 1 cycle when granted immediately; each channel is served at most once per 2 cycles.
REQ-018 In a cycle with no grant, ack SHALL be 0, det_valid=0, and det_ch/det SHALL hold their previous values.
REQ-019 ctx_clr[i]=1 without a grant of i SHALL set the context of i to run=0, last_bit=0 at the edge.
REQ-020 ctx_clr[i]=1 in the same cycle as a grant of i SHALL be treated as clear-then-consume: run=1, last_bit=w[i], det=0, ack issued.
REQ-021 Requesters SHALL hold req and w stable until ack; a request dropped before ack SHALL be ignored, with no partial effect.

Reset
REQ-022 With reset=1 at an edge, all contexts SHALL become run=0, last_bit=0.
REQ-023 With reset=1 at an edge, the outputs SHALL become ack=0, det_valid=0, det_ch=0, det=0, and the round-robin pointer SHALL become 3 so that channel 0 has first priority.
REQ-024 Reset SHALL override any grant or ctx_clr in the same cycle; a request pending during reset is not acked and is re-arbitrated after reset deasserts.

Configuration
REQ-025 With macro SEQ_SCHED_RR_EN defined, the arbiter SHALL be round-robin: the search starts at pointer+1 modulo 4, and the pointer updates to g on each grant.
REQ-026 With SEQ_SCHED_RR_EN undefined, the arbiter SHALL be fixed priority (lowest eligible index wins), the pointer SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Reset, then req=0001 with w[0] sequence 1,1,1,1,1 (req held, new bit after each ack) -> det on acks = 0,0,0,1,1, with det_ch=0 each time.
REQ-028 Channel 0 bits 1,1,0,0,0,0 -> det = 0,0,0,0,0,1; the run resets on a bit change.
REQ-029 RR_EN build, req=1111 held constantly -> grant order 0,1,2,3,0,...; no channel acked in two consecutive cycles.
REQ-030 Non-RR build, req=1111 held constantly -> acks alternate ch0 and ch1 (ch0 masked on its ack cycle); ch2 and ch3 are never acked.
REQ-031 Ch2 run=3 of 1s, then ctx_clr[2]=1 with a grant of ch2 and w[2]=1 -> det=0; the next three 1s give det=0,0,1.
REQ-032 Reset asserted mid-stream on ch1 at run=3 -> ack=0 during reset; after reset, four 1s are needed before det=1.
